// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and the receive path:
//   - state_t      : host transmit FSM encoding (S_IDLE .. S_WAIT_IDLE)
//   - ERR_*        : err_code values reported by ps2_host_tx
//   - CMD_* / RSP_ / BRK_ : common PS/2 keyboard command/response bytes
//   - odd_parity() : parity bit that makes data+parity carry an odd number of ones
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] BRK_CODE     = 8'hF0;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// -----------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for the raw PS2_CLK / PS2_DAT pins plus a one-cycle
// pulse when the synchronized clock falls. Shared by transmit and receive.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   ps2_clk_in/dat_in  raw pin levels
//   clk_s / dat_s      synchronized levels (reset to 1 = idle bus)
//   clk_fall           1-cycle pulse on synchronized clk 1->0
// -----------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Synchronizer chains and previous clock level, idle-high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, device ACK. Open-drain pins are driven by the top
// level as (oe ? 1'b0 : 1'bz).
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before RTS
//   TIMEOUT_CYCLES  watchdog limit from RTS (only with PS2_TX_TIMEOUT_EN)
// Optional feature macro: PS2_TX_TIMEOUT_EN (watchdog, err_code 10).
// Ports:
//   CLOCK_50, resetn            clock, async active-low reset
//   cmd_data/cmd_valid/cmd_ready command byte handshake (ready only in S_IDLE)
//   busy                        high in every state except S_IDLE
//   tx_done / tx_error          one-cycle end-of-frame pulses (mutually exclusive)
//   err_code                    cause of last error, held until next accept
//   ps2_clk_in / ps2_dat_in     raw pin levels
//   ps2_clk_oe / ps2_dat_oe     1 = pull the line low
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 750000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic clk_s;
    logic dat_s;
    logic clk_fall;

    ps2_sync_edge u_sync (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_s      (clk_s),
        .dat_s      (dat_s),
        .clk_fall   (clk_fall)
    );

    state_t           state_q,    state_d;
    logic [INH_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [8:0]       shift_q,    shift_d;     // {parity, data}, shifted out LSB first
    logic             clk_oe_q,   clk_oe_d;
    logic             dat_oe_q,   dat_oe_d;
    logic             tx_done_q,  tx_done_d;
    logic             tx_error_q, tx_error_d;
    logic [1:0]       err_q,      err_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] wd_q, wd_d;
`endif

    // Next-state and next-output logic for the transmit FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd_valid) begin
                    shift_d   = {odd_parity(cmd_data), cmd_data};
                    err_d     = ERR_NONE;
                    cnt_d     = '0;
                    bit_cnt_d = 4'd0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;           // start bit presented with clock still held
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + INH_W'(1);
                end
            end
            S_RTS: begin
                clk_oe_d  = 1'b0;              // release clock; data stays low as start bit
                dat_oe_d  = 1'b1;
                bit_cnt_d = 4'd0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (clk_fall) begin
                    // Falls 1..8 carry data bits, fall 9 carries parity
                    dat_oe_d  = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (clk_fall) begin
                    dat_oe_d = 1'b0;           // stop bit = released line
                    state_d  = S_ACK;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (!dat_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        tx_error_d = 1'b1;
                        err_d      = ERR_NOACK;
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog runs from RTS to the end of the frame and overrides any other outcome
        if ((state_q == S_IDLE) || (state_q == S_INHIBIT)) begin
            wd_d = 20'd0;
        end else if (wd_q == WD_LAST) begin
            wd_d       = 20'd0;
            clk_oe_d   = 1'b0;
            dat_oe_d   = 1'b0;
            tx_done_d  = 1'b0;
            tx_error_d = 1'b1;
            err_d      = ERR_TIMEOUT;
            state_d    = S_IDLE;
        end else begin
            wd_d = wd_q + 20'd1;
        end
`endif
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
            err_q      <= err_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wd_q <= 20'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = tx_done_q;
    assign tx_error   = tx_error_q;
    assign err_code   = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device drives the
// clock (fast half period to keep runs short), samples data on rising edges and
// optionally ACKs on clock 11. Expected bytes/parity come from a simple
// ones-count model. Define PS2_TX_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 5000;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready, busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low, dev_dat_low;
    logic       ps2_clk_in, ps2_dat_in;

    // Wired-AND open-drain bus with pull-ups
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // End-of-frame monitor
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;
    logic [1:0] last_err = 2'b00;
    logic       prev_err = 1'b0;
    logic       ready_after_err = 1'b0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) begin
            err_cnt  <= err_cnt + 1;
            last_err <= err_code;
        end
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if (prev_err) ready_after_err <= cmd_ready;
        prev_err <= tx_error;
    end

    // Device receive capture
    logic [7:0] rx_byte;
    logic       rx_par, rx_stop;

    function automatic logic exp_parity(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Device model: wait for RTS, then clock n_falls pulses (returns with clock held low if < 11)
    task automatic device(input bit ack, input int n_falls, output bit ok);
        int t;
        ok = 1'b0;
        rx_byte = 8'h00; rx_par = 1'b0; rx_stop = 1'b0;
        t = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < INH + 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= INH + 100) return;
        ok = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11 && ack) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == n_falls && n_falls < 11) return;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 8)       rx_byte[k-1] = ps2_dat_in;
            else if (k == 9)  rx_par  = ps2_dat_in;
            else if (k == 10) rx_stop = ps2_dat_in;
            else              dev_dat_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic wait_end(input int total0);
        int t;
        t = 0;
        while ((done_cnt + err_cnt) <= total0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input string name);
        int d0, e0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt;
        send(b);
        device(1'b1, 11, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_rts: no RTS seen within bound", name); end
        wait_end(d0 + e0);
        n_checks++;
        if (rx_byte !== b) begin n_fail++; $display("FAIL %s_byte: got %h want %h", name, rx_byte, b); end
        n_checks++;
        if (rx_par !== exp_parity(b)) begin n_fail++; $display("FAIL %s_parity: got %b want %b", name, rx_par, exp_parity(b)); end
        n_checks++;
        if (rx_stop !== 1'b1) begin n_fail++; $display("FAIL %s_stop: got %b want 1", name, rx_stop); end
        n_checks++;
        if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
            n_fail++;
            $display("FAIL %s_end: done %0d err %0d want done %0d err %0d", name, done_cnt - d0, err_cnt - e0, 1, 0);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: ready %b busy %b want 1 0", name, cmd_ready, busy); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_dat_oe} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 10000000",
                     {cmd_ready, busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_dat_oe});
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_set_leds();
        run_frame(CMD_SET_LEDS, "set_leds");
    endtask

    task automatic test_parity();
        logic [7:0] b;
        run_frame(8'h01, "par_01");
        run_frame(CMD_RESET, "par_ff");
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            run_frame(b, "rand");
        end
    endtask

    task automatic test_noack();
        logic [7:0] b;
        int d0, e0;
        bit ok;
        b = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt;
        send(b);
        device(1'b0, 11, ok);
        wait_end(d0 + e0);
        n_checks++;
        if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL noack_end: err %0d done %0d want err 1 done 0", err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if (last_err !== ERR_NOACK || err_code !== ERR_NOACK) begin
            n_fail++;
            $display("FAIL noack_code: pulse %b held %b want 01", last_err, err_code);
        end
        n_checks++;
        if (ready_after_err !== 1'b1) begin n_fail++; $display("FAIL noack_ready: got %b want 1", ready_after_err); end
        n_checks++;
        if (rx_byte !== b) begin n_fail++; $display("FAIL noack_byte: got %h want %h", rx_byte, b); end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        send(8'($urandom_range(0, 255)));
        t = 0;
        while (tx_error !== 1'b1 && t < INH + TMO + 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t < INH + TMO - 2 || t > INH + TMO + 2) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles want %0d +-2", t, INH + TMO);
        end
        n_checks++;
        if (err_code !== ERR_TIMEOUT || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: err %b clk_oe %b dat_oe %b want 10 0 0", err_code, ps2_clk_oe, ps2_dat_oe);
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_reset_midframe();
        logic [7:0] b;
        bit ok;
        b = 8'($urandom_range(0, 255)) & 8'hF7;   // bit 3 = 0 so the line is pulled after fall 4
        send(b);
        device(1'b1, 4, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (ps2_dat_oe !== ~b[3] || ps2_clk_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bit3: dat_oe %b clk_oe %b want %b 0", ps2_dat_oe, ps2_clk_oe, ~b[3]);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: clk_oe %b dat_oe %b busy %b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy);
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(CMD_ENABLE, "after_reset");
    endtask

    task automatic test_back_to_back_ignore();
        logic [7:0] b;
        int t, inh, d0, e0;
        bit ok;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA) b = 8'h55;
        d0 = done_cnt; e0 = err_cnt;
        send(b);
        t = 0; inh = 0;
        while (ps2_dat_oe !== 1'b1 && t < INH + 100) begin
            if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh++;
            if (t == 100) begin
                n_checks++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_flags: ready %b busy %b want 0 1", cmd_ready, busy);
                end
                cmd_data = 8'hAA; cmd_valid = 1'b1;
            end
            if (t == 101) cmd_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (inh !== INH) begin n_fail++; $display("FAIL inhibit_len: got %0d want %0d", inh, INH); end
        device(1'b1, 11, ok);
        wait_end(d0 + e0);
        n_checks++;
        if (rx_byte !== b) begin n_fail++; $display("FAIL ignore_byte: got %h want %h", rx_byte, b); end
        n_checks++;
        if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ignore_done: got %0d want 1", done_cnt - d0); end
        repeat (INH + 200) begin
            @(negedge clk);
            if (busy !== 1'b0) break;
        end
        n_checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_queued: busy %b clk_oe %b want 0 0", busy, ps2_clk_oe);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL done_and_error: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_noack();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midframe();
        test_back_to_back_ignore();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_800_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
